// File: rtl/pattern_tb_pkg.sv
// Shared types and constants for the pattern stimulus driver: FSM states and the
// LFSR/MISR polynomial and fallback seed.
package pattern_tb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StApply,
    StSettle,
    StCapture,
    StDone
  } state_e;

  localparam logic [15:0] POLY         = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr16_step.sv
// One step of a 16-bit Galois right-shift register; shared by the stimulus LFSR
// and the response-compacting MISR.
module lfsr16_step
  import pattern_tb_pkg::*;
(
  input  logic [15:0] x,
  output logic [15:0] y
);

  assign y = (x >> 1) ^ (x[0] ? POLY : 16'h0000);

endmodule

// File: rtl/pattern_stim_driver.sv
// Drives LFSR stimulus into a pattern netlist, waits for it to settle, and folds
// each response into a MISR signature.
module pattern_stim_driver
  import pattern_tb_pkg::*;
#(
  parameter int unsigned IN_W       = 11,
  parameter int unsigned OUT_W      = 9,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             start,
  input  logic [15:0]      num_vec,
  input  logic [15:0]      seed,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic [15:0]      signature,
  output logic [15:0]      vec_cnt
);

  localparam int unsigned SettleW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYC - 1);

  state_e             state;
  logic [15:0]        num_vec_q;
  logic [15:0]        seed_q;
  logic [15:0]        lfsr;
  logic [15:0]        misr;
  logic [SettleW-1:0] settle_cnt;

  logic [15:0] lfsr_next;
  logic [15:0] misr_step;
  logic [15:0] misr_next;

  lfsr16_step u_lfsr_step (
    .x (lfsr),
    .y (lfsr_next)
  );

  lfsr16_step u_misr_step (
    .x (misr),
    .y (misr_step)
  );

  assign misr_next = misr_step ^ 16'(resp);

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      state      <= StIdle;
      num_vec_q  <= 16'h0000;
      seed_q     <= 16'h0000;
      lfsr       <= DEFAULT_SEED;
      misr       <= 16'h0000;
      settle_cnt <= '0;
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      signature  <= 16'h0000;
      vec_cnt    <= 16'h0000;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            num_vec_q <= num_vec;
            seed_q    <= seed;
            busy      <= 1'b1;
            state     <= StLoad;
          end
        end
        StLoad: begin
          lfsr    <= (seed_q == 16'h0000) ? DEFAULT_SEED : seed_q;
          misr    <= 16'h0000;
          vec_cnt <= 16'h0000;
          if (num_vec_q == 16'h0000) begin
            // Empty run: the freshly cleared MISR is the signature.
            signature <= 16'h0000;
            done      <= 1'b1;
            state     <= StDone;
          end else begin
            state <= StApply;
          end
        end
        StApply: begin
          stim       <= lfsr[IN_W-1:0];
          lfsr       <= lfsr_next;
          settle_cnt <= SettleLast;
          state      <= StSettle;
        end
        StSettle: begin
          if (settle_cnt == '0) begin
            state <= StCapture;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        StCapture: begin
          misr    <= misr_next;
          vec_cnt <= vec_cnt + 16'd1;
          if (vec_cnt + 16'd1 == num_vec_q) begin
            signature <= misr_next;
            done      <= 1'b1;
            state     <= StDone;
          end else begin
            state <= StApply;
          end
        end
        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_stim_driver.sv
// Directed and randomized runs of pattern_stim_driver against a vector-level model
// of the LFSR stimulus sequence, MISR signature and run timing.
module tb_pattern_stim_driver;

  localparam int unsigned IN_W       = 11;
  localparam int unsigned OUT_W      = 9;
  localparam int unsigned SETTLE_CYC = 2;
  localparam int          P          = SETTLE_CYC + 2;

  logic             clk;
  logic             rst;
  logic             start;
  logic [15:0]      num_vec;
  logic [15:0]      seed;
  logic [IN_W-1:0]  stim;
  logic [OUT_W-1:0] resp;
  logic             busy;
  logic             done;
  logic [15:0]      signature;
  logic [15:0]      vec_cnt;

  int errors = 0;
  int checks = 0;

  logic             use_const;
  logic [OUT_W-1:0] cval;
  logic [IN_W-1:0]  last_stim;
  logic [15:0]      last_sig;

  pattern_stim_driver #(
    .IN_W       (IN_W),
    .OUT_W      (OUT_W),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .start          (start),
    .num_vec        (num_vec),
    .seed           (seed),
    .stim           (stim),
    .resp           (resp),
    .busy           (busy),
    .done           (done),
    .signature      (signature),
    .vec_cnt        (vec_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] step16(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Stand-in for the pattern netlist under test.
  function automatic logic [OUT_W-1:0] netlist(input logic [IN_W-1:0] s);
    logic [IN_W-1:0] t;
    t = IN_W'(s * IN_W'(5)) ^ (s >> 2) ^ IN_W'(11'h2A5);
    return t[OUT_W-1:0];
  endfunction

  always_comb resp = use_const ? cval : netlist(stim);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One run: start at cycle 0 edge, optional second start pulse at mid_start_cyc.
  task automatic run(input logic [15:0] n, input logic [15:0] sd, input int mid_start_cyc);
    logic [IN_W-1:0] es[$];
    logic [15:0]     l, m;
    logic [OUT_W-1:0] r;
    int c, idx, exp_done_c;
    bit seen_done;
    l = (sd == 16'h0000) ? 16'hACE1 : sd;
    m = 16'h0000;
    for (int i = 0; i < int'(n); i++) begin
      es.push_back(l[IN_W-1:0]);
      r = use_const ? cval : netlist(l[IN_W-1:0]);
      l = step16(l);
      m = step16(m) ^ 16'(r);
    end
    exp_done_c = 2 + int'(n) * P;

    @(negedge clk);
    start = 1'b1; num_vec = n; seed = sd;
    @(posedge clk); #1;
    num_vec = 16'($urandom); seed = 16'($urandom);
    c = 1; idx = 0; seen_done = 0;
    while (!seen_done && c <= exp_done_c + 4) begin
      start = (c == mid_start_cyc);
      if (c == mid_start_cyc) num_vec = 16'd1;
      if (c >= 3 && (c - 3) % P == 0 && idx < int'(n)) begin
        chk("stim_apply", 32'(stim), 32'(es[idx]));
        idx++;
      end
      if (c >= 3 && (c - 3) % P == SETTLE_CYC && idx > 0)
        chk("stim_stable", 32'(stim), 32'(es[idx-1]));
      if (done) begin
        seen_done = 1;
        chk("done_cycle", c, exp_done_c);
        chk("signature", 32'(signature), 32'(m));
        chk("vec_cnt", 32'(vec_cnt), 32'(n));
        chk("busy_in_done", 32'(busy), 1);
      end else begin
        chk("busy_run", 32'(busy), 1);
        @(posedge clk); #1;
        c++;
      end
    end
    chk("done_seen", 32'(seen_done), 1);
    start = 1'b0;
    if (n != 0) last_stim = es[es.size()-1];
    last_sig = m;
    @(posedge clk); #1;
    chk("idle_done", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_sig_hold", 32'(signature), 32'(last_sig));
    chk("idle_stim_hold", 32'(stim), 32'(last_stim));
  endtask

  initial begin
    bit any_done;
    rst = 1'b1; start = 1'b0; num_vec = 16'h0; seed = 16'h0;
    use_const = 1'b1; cval = '0; last_stim = '0; last_sig = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_stim", 32'(stim), 0);
    chk("rst_sig", 32'(signature), 0);
    chk("rst_vec_cnt", 32'(vec_cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    // seed 1, two vectors, zero response
    run(16'd2, 16'h0001, -1);
    chk("r030_sig", 32'(signature), 32'h0000);
    chk("r030_last_stim", 32'(stim), 32'h400);

    // seed 1, two vectors, response constant 1
    cval = 9'h001;
    run(16'd2, 16'h0001, -1);
    chk("r031_sig", 32'(signature), 32'hB401);

    // empty run
    run(16'd0, 16'h1234, -1);
    chk("r032_sig", 32'(signature), 32'h0000);
    chk("r032_vec_cnt", 32'(vec_cnt), 32'h0);

    // zero seed falls back to 0xACE1
    cval = 9'h0;
    run(16'd1, 16'h0000, -1);
    chk("r033_stim", 32'(stim), 32'h4E1);

    // second start mid-run is ignored
    use_const = 1'b0;
    run(16'd3, 16'hBEEF, 4);
    chk("r034_vec_cnt", 32'(vec_cnt), 32'd3);

    // randomized runs against the model
    for (int k = 0; k < 8; k++) begin
      logic [15:0] sd;
      sd = (k == 3) ? 16'h0000 : 16'($urandom);
      run(16'($urandom_range(1, 6)), sd, -1);
    end

    // reset during SETTLE of the first of three vectors
    use_const = 1'b1; cval = 9'h1F3;
    @(negedge clk);
    start = 1'b1; num_vec = 16'd3; seed = 16'h5A5A;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("r035_busy", 32'(busy), 0);
    chk("r035_done", 32'(done), 0);
    chk("r035_sig", 32'(signature), 0);
    chk("r035_vec_cnt", 32'(vec_cnt), 0);
    chk("r035_stim", 32'(stim), 0);
    any_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) any_done = 1;
    end
    chk("r035_no_resume", 32'(any_done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
